// File: rtl/pzbcm_fifo_upsizer.sv
// rtl/pzbcm_fifo_upsizer.sv - packs RATIO narrow FWFT FIFO entries into one wide word
// Partial words leave via flush; output is a registered valid/ready stage with per-slot strobes.
module pzbcm_fifo_upsizer #(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = WIDTH * RATIO,
  parameter int CNT_WIDTH = $clog2(RATIO)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_empty,
  output logic                 o_pop,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic [RATIO-1:0]     o_strobe
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RATIO - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [RATIO-1:0]     msk_q, msk_d;
  logic                 fp_q, fp_d;
  logic                 valid_q, valid_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [RATIO-1:0]     strb_q, strb_d;

  logic                 out_free;
  logic                 is_last;
  logic                 accept;
  logic                 pop;
  logic [OUT_WIDTH-1:0] acc_w;
  logic [RATIO-1:0]     msk_w;

  always_comb begin
    out_free = !valid_q || i_ready;
    is_last  = (cnt_q == LAST);
    accept   = !fp_q && !(is_last && !out_free);
    pop      = !i_rst && !i_empty && accept;

    // Word as it stands after this cycle's pop, used by both completion and flush
    acc_w = acc_q;
    msk_w = msk_q;
    for (int k = 0; k < RATIO; k++) begin
      if (pop && (cnt_q == CNT_WIDTH'(k))) begin
        acc_w[k*WIDTH +: WIDTH] = i_data;
        msk_w[k]                = 1'b1;
      end
    end

    cnt_d   = cnt_q;
    acc_d   = acc_q;
    msk_d   = msk_q;
    fp_d    = fp_q;
    valid_d = valid_q && !i_ready;
    data_d  = data_q;
    strb_d  = strb_q;

    if (pop && is_last) begin
      valid_d = 1'b1;
      data_d  = acc_w;
      strb_d  = '1;
      cnt_d   = '0;
      acc_d   = '0;
      msk_d   = '0;
      fp_d    = 1'b0;
    end else if (i_flush || fp_q) begin
      if (msk_w == '0) begin
        fp_d = 1'b0;
      end else if (out_free) begin
        valid_d = 1'b1;
        data_d  = acc_w;
        strb_d  = msk_w;
        cnt_d   = '0;
        acc_d   = '0;
        msk_d   = '0;
        fp_d    = 1'b0;
      end else begin
        // Hold the partial word and stall pops until the output register drains
        acc_d = acc_w;
        msk_d = msk_w;
        cnt_d = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        fp_d  = 1'b1;
      end
    end else if (pop) begin
      acc_d = acc_w;
      msk_d = msk_w;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      msk_q   <= '0;
      fp_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      msk_q   <= msk_d;
      fp_q    <= fp_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  assign o_pop    = pop;
  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign o_strobe = strb_q;

endmodule

// File: tb/tb_pzbcm_fifo_upsizer.sv
// tb/tb_pzbcm_fifo_upsizer.sv - vector table, corner sequences and random run against a queue model
module tb_pzbcm_fifo_upsizer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_empty;
  logic        o_pop;
  logic [7:0]  i_data;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [3:0]  o_strobe;

  always #5 clk = ~clk;

  pzbcm_fifo_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_empty  (i_empty),
    .o_pop    (o_pop),
    .i_data   (i_data),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_strobe (o_strobe)
  );

  typedef struct {
    bit          rst;
    bit          empty;
    logic [7:0]  data;
    bit          flush;
    bit          ready;
    bit          pop;
    bit          valid;
    logic [31:0] odata;
    logic [3:0]  ostrb;
  } rec_t;

  int checks = 0;
  int errors = 0;
  int row    = 0;

  rec_t tbl[$];
  rec_t seq[$];

  // Reference model: the word being built is a queue of entries
  logic [7:0]  mq[$];
  bit          m_fp;
  bit          m_ov;
  logic [31:0] m_od;
  logic [3:0]  m_os;

  function automatic rec_t mk(bit rst, bit empty, logic [7:0] data, bit flush, bit ready,
                              bit pop, bit valid, logic [31:0] odata, logic [3:0] ostrb);
    rec_t r;
    r.rst = rst; r.empty = empty; r.data = data; r.flush = flush; r.ready = ready;
    r.pop = pop; r.valid = valid; r.odata = odata; r.ostrb = ostrb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic m_emit();
    m_od = '0;
    foreach (mq[i]) m_od[i*WIDTH +: WIDTH] = mq[i];
    m_os = 4'((1 << mq.size()) - 1);
    m_ov = 1'b1;
    mq.delete();
    m_fp = 1'b0;
  endtask

  task automatic step(input rec_t r, input bit use_tbl);
    bit free, epop, load;
    i_rst = r.rst; i_empty = r.empty; i_data = r.data; i_flush = r.flush; i_ready = r.ready;
    if (r.rst) begin
      mq.delete(); m_fp = 1'b0; m_ov = 1'b0; m_od = '0; m_os = '0;
    end
    free = !m_ov || r.ready;
    epop = !r.rst && !r.empty && !m_fp && !(mq.size() == RATIO - 1 && !free);
    @(negedge clk);
    chk("pop_model",   o_pop,    32'(epop));
    chk("valid_model", o_valid,  32'(m_ov));
    chk("data_model",  o_data,   m_od);
    chk("strb_model",  o_strobe, 32'(m_os));
    if (use_tbl) begin
      chk("pop_vec",   o_pop,    32'(r.pop));
      chk("valid_vec", o_valid,  32'(r.valid));
      chk("data_vec",  o_data,   r.odata);
      chk("strb_vec",  o_strobe, 32'(r.ostrb));
    end
    if (!r.rst) begin
      load = 1'b0;
      if (epop) mq.push_back(r.data);
      if (mq.size() == RATIO) begin
        m_emit(); load = 1'b1;
      end else if (r.flush || m_fp) begin
        if (mq.size() == 0) m_fp = 1'b0;
        else if (free) begin m_emit(); load = 1'b1; end
        else m_fp = 1'b1;
      end
      if (!load && free) m_ov = 1'b0;
    end
    row++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq();
    foreach (seq[i]) step(seq[i], 1'b1);
    seq.delete();
  endtask

  initial begin
    i_rst = 1'b1; i_empty = 1'b1; i_data = '0; i_flush = 1'b0; i_ready = 1'b0;

    // Streaming
    tbl.push_back(mk(1,1,8'h00,0,1, 0,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h11,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h22,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h33,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h44,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h55,0,1, 1,1,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h66,0,1, 1,0,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h77,0,1, 1,0,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h88,0,1, 1,0,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h99,0,1, 1,1,32'h88776655,4'hF));
    // Backpressure
    tbl.push_back(mk(1,1,8'h00,0,1, 0,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h11,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h22,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h33,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h44,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'h55,0,0, 1,1,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h66,0,0, 1,1,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h77,0,0, 1,1,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h88,0,0, 0,1,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h88,0,0, 0,1,32'h44332211,4'hF));
    tbl.push_back(mk(0,0,8'h88,0,1, 1,1,32'h44332211,4'hF));
    tbl.push_back(mk(0,1,8'h00,0,1, 0,1,32'h88776655,4'hF));
    // Partial flush, then a full word landing from slot 0
    tbl.push_back(mk(1,1,8'h00,0,1, 0,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'hA1,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,0,8'hB2,0,1, 1,0,32'h0,4'h0));
    tbl.push_back(mk(0,1,8'h00,1,1, 0,0,32'h0,4'h0));
    tbl.push_back(mk(0,1,8'h00,0,1, 0,1,32'h0000B2A1,4'h3));
    tbl.push_back(mk(0,0,8'hC3,0,1, 1,0,32'h0000B2A1,4'h3));
    tbl.push_back(mk(0,0,8'hD4,0,1, 1,0,32'h0000B2A1,4'h3));
    tbl.push_back(mk(0,0,8'hE5,0,1, 1,0,32'h0000B2A1,4'h3));
    tbl.push_back(mk(0,0,8'hF6,0,1, 1,0,32'h0000B2A1,4'h3));
    tbl.push_back(mk(0,1,8'h00,0,1, 0,1,32'hF6E5D4C3,4'hF));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

    // Flush blocked by a full output register; a repeated flush is absorbed
    seq.push_back(mk(1,1,8'h00,0,1, 0,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h11,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h22,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h33,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h44,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h55,0,0, 1,1,32'h44332211,4'hF));
    seq.push_back(mk(0,1,8'h00,1,0, 0,1,32'h44332211,4'hF));
    seq.push_back(mk(0,0,8'h66,1,0, 0,1,32'h44332211,4'hF));
    seq.push_back(mk(0,0,8'h66,0,1, 0,1,32'h44332211,4'hF));
    seq.push_back(mk(0,0,8'h66,0,1, 1,1,32'h00000055,4'h1));
    seq.push_back(mk(0,0,8'h77,0,1, 1,0,32'h00000055,4'h1));
    seq.push_back(mk(0,0,8'h88,0,1, 1,0,32'h00000055,4'h1));
    seq.push_back(mk(0,0,8'h99,0,1, 1,0,32'h00000055,4'h1));
    seq.push_back(mk(0,1,8'h00,0,1, 0,1,32'h99887766,4'hF));
    seq.push_back(mk(0,1,8'h00,0,1, 0,0,32'h99887766,4'hF));
    run_seq();

    // Edge flushes: empty word, and flush on the completing pop
    seq.push_back(mk(1,1,8'h00,0,1, 0,0,32'h0,4'h0));
    seq.push_back(mk(0,1,8'h00,1,1, 0,0,32'h0,4'h0));
    seq.push_back(mk(0,1,8'h00,0,1, 0,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h01,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h02,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h03,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h04,1,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,1,8'h00,0,1, 0,1,32'h04030201,4'hF));
    seq.push_back(mk(0,1,8'h00,0,1, 0,0,32'h04030201,4'hF));
    seq.push_back(mk(0,1,8'h00,0,1, 0,0,32'h04030201,4'hF));
    run_seq();

    // Reset mid-word with an output word pending
    seq.push_back(mk(1,1,8'h00,0,1, 0,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h11,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h22,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h33,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h44,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h55,0,0, 1,1,32'h44332211,4'hF));
    seq.push_back(mk(0,0,8'h66,0,0, 1,1,32'h44332211,4'hF));
    seq.push_back(mk(1,0,8'h77,0,0, 0,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h01,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h02,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h03,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,0,8'h04,0,1, 1,0,32'h0,4'h0));
    seq.push_back(mk(0,1,8'h00,0,1, 0,1,32'h04030201,4'hF));
    run_seq();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rec_t r;
      r = mk(0,0,8'h00,0,0, 0,0,32'h0,4'h0);
      r.rst   = ($urandom_range(0, 199) == 0);
      r.empty = ($urandom_range(0, 9) < 3);
      r.data  = 8'($urandom);
      r.flush = ($urandom_range(0, 99) < 8);
      r.ready = ($urandom_range(0, 9) < 6);
      step(r, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
